// File: rtl/dif_usb_pkg.sv
// Purpose: shared definitions for the DIF USB command path (RX decoder today, TX framer later).
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package dif_usb_pkg;

  // Frame sync word that opens every command frame.
  localparam logic [15:0] HEADER_DEFAULT = 16'hAA55;

  // Maximum idle cycles between words inside a frame: 1 ms at 50 MHz.
  localparam int TIMEOUT_CYC_DEFAULT = 50000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ALEN = 2'd1,
    S_DATA = 2'd2,
    S_CSUM = 2'd3
  } cmd_state_t;

  // Error counters stick at all-ones rather than wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/cmd_gap_timer.sv
// Purpose: inter-word gap timer; flags when a frame has gone TIMEOUT_CYC cycles without a word.
// Latency: expire is combinational from the count register; count reaches TIMEOUT_CYC after that many idle cycles.
// Backpressure: none; clr (word strobe) always wins over expiry.
//
// Ports:
//   clk, rstn  : clock, synchronous active-low reset
//   clr        : word strobe, restarts the gap count
//   en         : counting enable (frame in progress); count held at 0 while low
//   expire     : one-cycle flag, count is at the limit and no word arrived this cycle
module cmd_gap_timer
  import dif_usb_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYC);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (clr || !en) begin
      cnt <= '0;
    end else if (cnt != LIMIT) begin
      // Hold at the limit; the decoder leaves the frame on expiry, which drops en.
      cnt <= cnt + 1'b1;
    end
  end

  assign expire = en && !clr && (cnt == LIMIT);

endmodule

// File: rtl/usb_cmd_decoder.sv
// Purpose: parses EP2 host frames {HEADER, addr/len, data..., [checksum]} into register writes.
// Latency: 1 cycle from rx_sync_in to reg_wr_out / pkt_done_out / pkt_err_out; timeout pulse 1 cycle after gap limit.
// Backpressure: none; accepts one word every 2 cycles in every state, input is never stalled.
//
// Ports:
//   clk, rstn                     : clock, synchronous active-low reset
//   rx_sync_in, rx_data_in        : word strobe and word from the slave-FIFO driver
//   reg_wr_out, reg_addr_out,
//   reg_wdata_out                 : register-write strobe, address (auto-increment), data
//   pkt_done_out, pkt_err_out     : frame completed / aborted or bad checksum (one-cycle pulses)
//   err_cnt_out                   : saturating error count, cleared only by reset
//
// Build option: define CMD_CHECKSUM_EN to expect and verify a trailing XOR checksum word.
// Without it the frame ends at the last data word and only timeouts raise pkt_err_out.
module usb_cmd_decoder
  import dif_usb_pkg::*;
#(
  parameter logic [15:0] HEADER      = HEADER_DEFAULT,
  parameter int          TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        rx_sync_in,
  input  logic [15:0] rx_data_in,
  output logic        reg_wr_out,
  output logic [7:0]  reg_addr_out,
  output logic [15:0] reg_wdata_out,
  output logic        pkt_done_out,
  output logic        pkt_err_out,
  output logic [7:0]  err_cnt_out
);

  cmd_state_t  state;
  logic [7:0]  addr_cnt;
  logic [7:0]  remain;
  logic        gap_en;
  logic        gap_expire;
`ifdef CMD_CHECKSUM_EN
  logic [15:0] csum_acc;
`endif

  assign gap_en = (state != S_IDLE);

  cmd_gap_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_gap_timer (
    .clk    (clk),
    .rstn   (rstn),
    .clr    (rx_sync_in),
    .en     (gap_en),
    .expire (gap_expire)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state         <= S_IDLE;
      addr_cnt      <= 8'd0;
      remain        <= 8'd0;
      reg_wr_out    <= 1'b0;
      reg_addr_out  <= 8'd0;
      reg_wdata_out <= 16'd0;
      pkt_done_out  <= 1'b0;
      pkt_err_out   <= 1'b0;
      err_cnt_out   <= 8'd0;
`ifdef CMD_CHECKSUM_EN
      csum_acc      <= 16'd0;
`endif
    end else begin
      reg_wr_out   <= 1'b0;
      pkt_done_out <= 1'b0;
      pkt_err_out  <= 1'b0;

      // A word arriving in the expiry cycle restarts the gap, so it takes priority.
      if (rx_sync_in) begin
        case (state)
          S_IDLE: begin
            // Non-header words between frames are line noise; drop them silently.
            if (rx_data_in == HEADER) state <= S_ALEN;
          end

          S_ALEN: begin
            addr_cnt <= rx_data_in[15:8];
            remain   <= rx_data_in[7:0];
`ifdef CMD_CHECKSUM_EN
            csum_acc <= rx_data_in;
`endif
            if (rx_data_in[7:0] == 8'd0) begin
`ifdef CMD_CHECKSUM_EN
              state <= S_CSUM;
`else
              pkt_done_out <= 1'b1;
              state        <= S_IDLE;
`endif
            end else begin
              state <= S_DATA;
            end
          end

          S_DATA: begin
            // Writes commit immediately; a later checksum failure does not undo them.
            // HEADER-valued words are plain data here, not a resync.
            reg_wr_out    <= 1'b1;
            reg_addr_out  <= addr_cnt;
            reg_wdata_out <= rx_data_in;
            addr_cnt      <= addr_cnt + 8'd1;
            remain        <= remain - 8'd1;
`ifdef CMD_CHECKSUM_EN
            csum_acc      <= csum_acc ^ rx_data_in;
`endif
            if (remain == 8'd1) begin
`ifdef CMD_CHECKSUM_EN
              state <= S_CSUM;
`else
              pkt_done_out <= 1'b1;
              state        <= S_IDLE;
`endif
            end
          end

`ifdef CMD_CHECKSUM_EN
          S_CSUM: begin
            if (rx_data_in == csum_acc) begin
              pkt_done_out <= 1'b1;
            end else begin
              pkt_err_out <= 1'b1;
              err_cnt_out <= sat_inc8(err_cnt_out);
            end
            state <= S_IDLE;
          end
`endif

          default: state <= S_IDLE;
        endcase
      end else if (gap_expire) begin
        pkt_err_out <= 1'b1;
        err_cnt_out <= sat_inc8(err_cnt_out);
        state       <= S_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_usb_cmd_decoder.sv
// Purpose: self-checking bench for usb_cmd_decoder against a frame-level reference model.
// Latency: expects every result one cycle after the word strobe, timeout one cycle after the gap limit.
// Backpressure: n/a; words are driven at most every other cycle.
`timescale 1ns/1ps
module tb_usb_cmd_decoder;

  localparam logic [15:0] HDR = 16'hAA55;
  localparam int          TO  = 100;
`ifdef CMD_CHECKSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        rx_sync = 1'b0;
  logic [15:0] rx_data = 16'd0;
  logic        reg_wr;
  logic [7:0]  reg_addr;
  logic [15:0] reg_wdata;
  logic        pkt_done;
  logic        pkt_err;
  logic [7:0]  err_cnt;

  usb_cmd_decoder #(
    .HEADER      (HDR),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .rx_sync_in    (rx_sync),
    .rx_data_in    (rx_data),
    .reg_wr_out    (reg_wr),
    .reg_addr_out  (reg_addr),
    .reg_wdata_out (reg_wdata),
    .pkt_done_out  (pkt_done),
    .pkt_err_out   (pkt_err),
    .err_cnt_out   (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        wr;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic        done;
    logic        err;
    logic [7:0]  cnt;
  } obs_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  // Model of what the register-file side should currently see.
  logic [7:0]  m_addr  = 8'd0;
  logic [15:0] m_wdata = 16'd0;
  int          m_err   = 0;
  logic [15:0] dq[$];
  obs_t        got_q[$];
  obs_t        exp_q[$];

  function automatic obs_t sample();
    obs_t s;
    s.wr = reg_wr; s.addr = reg_addr; s.wdata = reg_wdata;
    s.done = pkt_done; s.err = pkt_err; s.cnt = err_cnt;
    return s;
  endfunction

  function automatic obs_t quiet();
    obs_t e;
    e = '0;
    e.addr = m_addr; e.wdata = m_wdata; e.cnt = 8'(m_err);
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic m_error();
    if (m_err < 255) m_err++;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      tick();
      got_q.push_back(sample());
      exp_q.push_back(quiet());
    end
  endtask

  task automatic send(input logic [15:0] w, input obs_t e);
    rx_sync = 1'b1;
    rx_data = w;
    tick();
    rx_sync = 1'b0;
    got_q.push_back(sample());
    exp_q.push_back(e);
  endtask

  // Builds a frame from dq[0..len-1], sends its first nw words with the given strobe spacing,
  // and records what each cycle should look like from the frame position of each word.
  task automatic run_frame(input logic [7:0] addr, input int len, input bit bad,
                           input int nw, input int gap);
    logic [15:0] fw[$];
    logic [15:0] x;
    obs_t        e;
    x = {addr, 8'(len)};
    fw.push_back(HDR);
    fw.push_back(x);
    for (int i = 0; i < len; i++) begin
      fw.push_back(dq[i]);
      x ^= dq[i];
    end
    if (CS) fw.push_back(bad ? ~x : x);
    for (int k = 0; k < fw.size() && k < nw; k++) begin
      if (k >= 2 && k < len + 2) begin
        m_addr  = addr + 8'(k - 2);
        m_wdata = fw[k];
      end
      e = quiet();
      if (k >= 2 && k < len + 2) e.wr = 1'b1;
      if (!CS && k == len + 1) e.done = 1'b1;
      if (CS && k == len + 2) begin
        if (bad) begin
          m_error();
          e = quiet();
          e.err = 1'b1;
        end else begin
          e.done = 1'b1;
        end
      end
      send(fw[k], e);
      idle(gap - 1);
    end
  endtask

  // Called one idle cycle after the last strobe of an unfinished frame.
  task automatic await_timeout();
    obs_t e;
    for (int j = 2; j <= TO + 2; j++) begin
      tick();
      e = quiet();
      if (j == TO + 1) begin
        m_error();
        e = quiet();
        e.err = 1'b1;
      end
      got_q.push_back(sample());
      exp_q.push_back(e);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    tick();
    tick();
    n_checks++;
    if (sample() !== obs_t'(0)) begin
      n_fail++;
      $display("FAIL reset_state got=%h exp=%h", sample(), obs_t'(0));
    end
    rstn = 1'b1;
    m_addr = 8'd0; m_wdata = 16'd0; m_err = 0;
    idle(3);
    foreach (got_q[i]) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL reset_idle cyc%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_basic();
    dq = '{16'h1234, 16'h5678};
    run_frame(8'h10, 2, 1'b0, 99, 2);
    idle(2);
    foreach (got_q[i]) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL basic cyc%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_bad_csum();
    dq = '{16'h1234, 16'h5678};
    run_frame(8'h10, 2, 1'b1, 99, 2);
    idle(2);
    foreach (got_q[i]) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL bad_csum cyc%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_no_csum();
    dq = '{16'hBEEF};
    run_frame(8'h05, 1, 1'b0, 99, 3);
    dq = '{};
    run_frame(8'h77, 0, 1'b0, 99, 2);
    foreach (got_q[i]) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL short_frame cyc%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_wrap();
    send(16'h0001, quiet());
    idle(1);
    send(16'hFFFF, quiet());
    idle(1);
    dq = '{16'hAAAA, 16'hAA55};
    run_frame(8'hFF, 2, 1'b0, 99, 2);
    foreach (got_q[i]) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL wrap_hdr_in_data cyc%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_timeout();
    dq = '{16'h0001, 16'h0002, 16'h0003};
    run_frame(8'h20, 3, 1'b0, 3, 2);
    await_timeout();
    dq = '{16'hC0DE};
    run_frame(8'h30, 1, 1'b0, 99, 2);
    foreach (got_q[i]) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL timeout cyc%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_gap_limit();
    dq = '{16'($urandom), 16'($urandom), 16'($urandom)};
    run_frame(8'($urandom), 3, 1'b0, 99, TO - 1);
    foreach (got_q[i]) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL gap_limit cyc%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid();
    dq = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    run_frame(8'h40, 4, 1'b0, 4, 2);
    rstn = 1'b0;
    tick();
    n_checks++;
    if (sample() !== obs_t'(0)) begin
      n_fail++;
      $display("FAIL reset_mid_state got=%h exp=%h", sample(), obs_t'(0));
    end
    rstn = 1'b1;
    m_addr = 8'd0; m_wdata = 16'd0; m_err = 0;
    idle(4);
    dq = '{16'h5555, 16'h6666};
    run_frame(8'h50, 2, 1'b0, 99, 2);
    foreach (got_q[i]) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL reset_mid cyc%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    logic [15:0] g;
    int          len;
    for (int f = 0; f < 40; f++) begin
      len = $urandom_range(0, 5);
      dq.delete();
      for (int i = 0; i < len; i++) dq.push_back(16'($urandom));
      run_frame(8'($urandom), len, CS && ($urandom_range(0, 3) == 0), 99, $urandom_range(2, 4));
      if ($urandom_range(0, 2) == 0) begin
        g = 16'($urandom);
        if (g == HDR) g = 16'h0000;
        send(g, quiet());
        idle(1);
      end
    end
    foreach (got_q[i]) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL random cyc%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_saturation();
    for (int n = 0; n < 300; n++) begin
      if (CS) begin
        dq = '{16'($urandom)};
        run_frame(8'($urandom), 1, 1'b1, 99, 2);
      end else begin
        dq = '{16'h0000};
        run_frame(8'($urandom), 1, 1'b0, 2, 2);
        await_timeout();
      end
      foreach (got_q[i]) begin
        n_checks++;
        if (got_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL saturation iter%0d cyc%0d got=%h exp=%h", n, i, got_q[i], exp_q[i]);
        end
      end
      got_q.delete(); exp_q.delete();
    end
    n_checks++;
    if (err_cnt !== 8'd255) begin
      n_fail++;
      $display("FAIL saturation_final got=%0d exp=255", err_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_csum();
    test_no_csum();
    test_wrap();
    test_timeout();
    test_gap_limit();
    test_reset_mid();
    test_random();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/usb_cmd_decoder.md
# usb_cmd_decoder

Frame parser directly downstream of the FX2LP slave-FIFO driver on the host-to-FPGA (EP2) path. It consumes the driver's single-cycle word strobes (`rx_sync`/`rx_data`) and extracts framed register-write commands. It emits one register-write strobe per data word, with an auto-incrementing address, to the DIF configuration register file. It reports frame completion, framing errors, checksum errors and inter-word timeouts.

## Interface
Parameters:
- `HEADER`, 16'hAA55: frame sync word.
- `TIMEOUT_CYC`, 50000: maximum idle cycles between words inside a frame (1 ms at 50 MHz). Valid range 2..65535.

Ports:
- `clk`, in, 1: system clock, 50 MHz. The only clock.
- `rstn`, in, 1: reset. Synchronous, active-low.
- `rx_sync_in`, in, 1: one-cycle strobe; `rx_data_in` is valid in this cycle. Never asserted on consecutive cycles.
- `rx_data_in`, in, 16: received word.
- `reg_wr_out`, out, 1: one-cycle register-write strobe.
- `reg_addr_out`, out, 8: write address.
- `reg_wdata_out`, out, 16: write data.
- `pkt_done_out`, out, 1: one-cycle pulse; the frame ended cleanly.
- `pkt_err_out`, out, 1: one-cycle pulse; the frame was aborted (timeout) or had a bad checksum.
- `err_cnt_out`, out, 8: error count. Saturates at 255.

## Operation
- Frame format: `HEADER`, then `{addr[7:0], len[7:0]}`, then `len` data words, then the checksum word.
- Checksum: 16-bit XOR of the addr/len word and all data words.
- FSM states: `S_IDLE`, `S_ALEN`, `S_DATA`, `S_CSUM`. Transitions occur only on `rx_sync_in` or on timeout.
- `S_IDLE`:
  - Word == `HEADER` → go to `S_ALEN`.
  - Any other word is discarded silently. No error is raised.
- `S_ALEN`:
  - Latch `addr` into the address counter and `len` into the remaining counter.
  - Seed the checksum accumulator with the word.
  - `len`==0 → go to `S_CSUM`; otherwise go to `S_DATA`.
- `S_DATA`:
  - Each word produces a write: `reg_wr_out`=1, `reg_addr_out`=current address, `reg_wdata_out`=word.
  - XOR the word into the accumulator, increment the address, decrement remaining.
  - Address wraps 8'hFF → 8'h00 without error.
  - A word equal to `HEADER` is treated as data, not as a resync.
  - Last word (remaining==1) → go to `S_CSUM`.
- `S_CSUM`:
  - Word == accumulator → `pkt_done_out` pulse.
  - Otherwise → `pkt_err_out` pulse and `err_cnt_out` increments.
  - Go to `S_IDLE` in both cases.
- Writes are committed as data words arrive. A checksum failure does not roll them back; host software re-sends the frame.
- Timeout:
  - The gap counter clears on every `rx_sync_in` and counts in every state except `S_IDLE`.
  - When the counter reaches `TIMEOUT_CYC` → `pkt_err_out` pulse, `err_cnt_out` increments, go to `S_IDLE`.
- Simultaneous word and timeout in the same cycle: the word wins and the timeout is ignored.
- `err_cnt_out` stays at 255 once saturated. It is cleared only by reset.

## Timing
- All outputs are registered.
- Latency: a write, done or error pulse appears on the cycle after the `rx_sync_in` that caused it. The timeout pulse appears on the cycle after the counter reaches `TIMEOUT_CYC`.
- Strobe/pulse width: `reg_wr_out`, `pkt_done_out` and `pkt_err_out` are each exactly one cycle.
- Held values: `reg_addr_out` and `reg_wdata_out` hold their last values between strobes.
- Reset (`rstn`=0 at a `clk` edge), including mid-frame:
  - FSM to `S_IDLE`.
  - All outputs to 0.
  - Gap counter, accumulator and `err_cnt_out` to 0.
  - A partial frame is dropped without an error pulse.
- Input rate: at most one word every 2 cycles. The block accepts a word in every state at that rate.

## Configuration
- Macro: `CMD_CHECKSUM_EN`.
- Defined: the frame carries a checksum word and `S_CSUM` behaves as described in Operation.
- Undefined:
  - `S_CSUM` and the accumulator are compiled out.
  - After the last data word (or after the addr/len word when `len`==0), `pkt_done_out` pulses on the same cycle as the last write, and the FSM goes to `S_IDLE`.
  - Checksum errors cannot occur; only timeouts raise `pkt_err_out`.

## Structure
- Shared package `dif_usb_pkg` holds the FSM state encoding, the `HEADER` default and the `TIMEOUT_CYC` default. The future TX-side framer reuses these.
- Sub-module `cmd_gap_timer`: the gap counter with clear and enable inputs and a one-cycle expiry output. Counter width is `$clog2(TIMEOUT_CYC+1)`.
- The FSM, counters and output registers live in `usb_cmd_decoder`.

## Test plan
- Frame AA55, 1002, 1234, 5678, checksum 1002^1234^5678 → writes (10,1234) and (11,5678), then `pkt_done_out`, `err_cnt_out`=0.
- The same frame with checksum 0000 → both writes still occur, `pkt_err_out` pulses, `err_cnt_out`=1.
- Garbage words 0001, FFFF, then frame AA55, FF02, AAAA, AA55, checksum → writes (FF,AAAA) and (00,AA55), then `pkt_done_out`. Covers wrap-around and `HEADER` inside data.
- Frame AA55, 2003, 0001, then 50000 idle cycles → `pkt_err_out` once, `err_cnt_out`=1. The next clean frame is accepted.
- Words arrive exactly at gap `TIMEOUT_CYC` - 1 → no timeout. Also drive `rstn` low for one cycle mid-`S_DATA` → all outputs 0, no pulse, the next frame is decoded correctly.
- With `CMD_CHECKSUM_EN` undefined: AA55, 0501, BEEF → write (05,BEEF) and `pkt_done_out` in the same cycle. Also 300 bad-checksum frames (macro defined) → `err_cnt_out` saturates at 255.
